// File: rtl/cache_wb_buffer.sv
// Writeback drain buffer: FIFO of dirty evicted lines issued as byte-masked memory writes.
// Optional macro CS_WB_MERGE_EN merges evictions into a matching non-head pending entry.
module cache_wb_buffer #(
  parameter int LINE_SIZE       = 16,
  parameter int LINE_ADDR_WIDTH = 26,
  parameter int DEPTH           = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       evict_valid,
  input  logic [LINE_ADDR_WIDTH-1:0] evict_addr,
  input  logic [LINE_SIZE*8-1:0]     evict_data,
  input  logic [LINE_SIZE-1:0]       evict_byteen,
  output logic                       evict_ready,
  output logic                       mem_req_valid,
  output logic [LINE_ADDR_WIDTH-1:0] mem_req_addr,
  output logic [LINE_SIZE*8-1:0]     mem_req_data,
  output logic [LINE_SIZE-1:0]       mem_req_byteen,
  input  logic                       mem_req_ready,
  input  logic [LINE_ADDR_WIDTH-1:0] lookup_addr,
  output logic                       lookup_hit,
  output logic                       empty,
  output logic                       full
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int DW = LINE_SIZE * 8;

  logic [LINE_ADDR_WIDTH-1:0] r_addr   [DEPTH];
  logic [DW-1:0]              r_data   [DEPTH];
  logic [LINE_SIZE-1:0]       r_byteen [DEPTH];
  logic [DEPTH-1:0]           r_valid;
  logic [PW-1:0]              r_rd_ptr;
  logic [PW-1:0]              r_wr_ptr;
  logic [CW-1:0]              r_count;

  logic             w_empty;
  logic             w_full;
  logic             w_dirty;
  logic             w_push;
  logic             w_pop;
  logic [DEPTH-1:0] w_valid_nxt;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_dirty = |evict_byteen;
  assign w_pop   = !w_empty && mem_req_ready;

`ifdef CS_WB_MERGE_EN
  logic          w_merge_match;
  logic [PW-1:0] w_merge_idx;
  logic          w_merge;

  // The head is excluded so the payload on mem_req never changes while offered.
  always_comb begin
    w_merge_match = 1'b0;
    w_merge_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_valid[i] && (PW'(i) != r_rd_ptr) && (r_addr[i] == evict_addr)) begin
        w_merge_match = 1'b1;
        w_merge_idx   = PW'(i);
      end
    end
  end

  assign evict_ready = !w_full || w_merge_match;
  assign w_merge     = evict_valid && w_dirty && w_merge_match;
  assign w_push      = evict_valid && evict_ready && w_dirty && !w_merge_match;
`else
  assign evict_ready = !w_full;
  assign w_push      = evict_valid && evict_ready && w_dirty;
`endif

  always_comb begin
    w_valid_nxt = r_valid;
    if (w_pop)  w_valid_nxt[r_rd_ptr] = 1'b0;
    if (w_push) w_valid_nxt[r_wr_ptr] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_valid  <= '0;
    end else begin
      r_valid <= w_valid_nxt;
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage carries no reset; validity is tracked by r_valid/r_count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_wr_ptr]   <= evict_addr;
      r_data[r_wr_ptr]   <= evict_data;
      r_byteen[r_wr_ptr] <= evict_byteen;
    end
`ifdef CS_WB_MERGE_EN
    if (w_merge) begin
      r_byteen[w_merge_idx] <= r_byteen[w_merge_idx] | evict_byteen;
      for (int b = 0; b < LINE_SIZE; b++) begin
        if (evict_byteen[b]) r_data[w_merge_idx][b*8 +: 8] <= evict_data[b*8 +: 8];
      end
    end
`endif
  end

  always_comb begin
    lookup_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_valid[i] && (r_addr[i] == lookup_addr)) lookup_hit = 1'b1;
    end
  end

  assign mem_req_valid  = !w_empty;
  assign mem_req_addr   = w_empty ? '0 : r_addr[r_rd_ptr];
  assign mem_req_data   = w_empty ? '0 : r_data[r_rd_ptr];
  assign mem_req_byteen = w_empty ? '0 : r_byteen[r_rd_ptr];
  assign empty          = w_empty;
  assign full           = w_full;

endmodule

// File: tb/tb_cache_wb_buffer.sv
// Table-driven bench for cache_wb_buffer plus hand sequences for async reset and merge/duplicate handling.
module tb_cache_wb_buffer;
  logic         clk;
  logic         reset;
  logic         evict_valid;
  logic [25:0]  evict_addr;
  logic [127:0] evict_data;
  logic [15:0]  evict_byteen;
  logic         evict_ready;
  logic         mem_req_valid;
  logic [25:0]  mem_req_addr;
  logic [127:0] mem_req_data;
  logic [15:0]  mem_req_byteen;
  logic         mem_req_ready;
  logic [25:0]  lookup_addr;
  logic         lookup_hit;
  logic         empty;
  logic         full;

  int checks = 0;
  int errors = 0;

  cache_wb_buffer #(.LINE_SIZE(16), .LINE_ADDR_WIDTH(26), .DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .evict_valid(evict_valid), .evict_addr(evict_addr), .evict_data(evict_data),
    .evict_byteen(evict_byteen), .evict_ready(evict_ready),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
    .mem_req_byteen(mem_req_byteen), .mem_req_ready(mem_req_ready),
    .lookup_addr(lookup_addr), .lookup_hit(lookup_hit), .empty(empty), .full(full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [25:0] a;
    logic [15:0] be;
    logic [7:0]  db;
    logic        rdy;
    logic [25:0] lk;
    logic        er;
    logic        mv;
    logic [25:0] ma;
    logic [15:0] mb;
    logic [7:0]  md;
    logic        hit;
    logic        emp;
    logic        fl;
  } vec_t;

  vec_t vt[27];

  function automatic vec_t mk(input logic v, input logic [25:0] a, input logic [15:0] be,
                              input logic [7:0] db, input logic rdy, input logic [25:0] lk,
                              input logic er, input logic mv, input logic [25:0] ma,
                              input logic [15:0] mb, input logic [7:0] md,
                              input logic hit, input logic emp, input logic fl);
    vec_t t;
    t.v = v; t.a = a; t.be = be; t.db = db; t.rdy = rdy; t.lk = lk;
    t.er = er; t.mv = mv; t.ma = ma; t.mb = mb; t.md = md;
    t.hit = hit; t.emp = emp; t.fl = fl;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [25:0] a, input logic [15:0] be,
                       input logic [127:0] d, input logic rdy, input logic [25:0] lk);
    evict_valid   = v;
    evict_addr    = a;
    evict_byteen  = be;
    evict_data    = d;
    mem_req_ready = rdy;
    lookup_addr   = lk;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_head(input string nm, input logic [25:0] a, input logic [15:0] be,
                          input logic [127:0] d);
    chk({nm, "_mv"}, 128'(mem_req_valid), 128'(1'b1));
    chk({nm, "_ma"}, 128'(mem_req_addr), 128'(a));
    chk({nm, "_mb"}, 128'(mem_req_byteen), 128'(be));
    chk({nm, "_md"}, mem_req_data, d);
  endtask

  logic [127:0] mdata;
  logic [127:0] merged;

  initial begin
    // v  addr   byteen  db  rdy lk     | er mv ma     mb       md  hit emp full
    vt[0]  = mk(0, 'h00, 'h0000, 'h00, 0, 'h10,  1, 0, 'h00, 'h0000, 'h00, 0, 1, 0);
    vt[1]  = mk(1, 'h10, 'hFFFF, 'hA5, 0, 'h10,  1, 0, 'h00, 'h0000, 'h00, 0, 1, 0);
    vt[2]  = mk(0, 'h00, 'h0000, 'h00, 0, 'h10,  1, 1, 'h10, 'hFFFF, 'hA5, 1, 0, 0);
    vt[3]  = mk(0, 'h00, 'h0000, 'h00, 1, 'h10,  1, 1, 'h10, 'hFFFF, 'hA5, 1, 0, 0);
    vt[4]  = mk(1, 'h20, 'h0000, 'h5A, 0, 'h20,  1, 0, 'h00, 'h0000, 'h00, 0, 1, 0);
    vt[5]  = mk(0, 'h00, 'h0000, 'h00, 0, 'h20,  1, 0, 'h00, 'h0000, 'h00, 0, 1, 0);
    vt[6]  = mk(1, 'h01, 'h000F, 'h11, 0, 'h01,  1, 0, 'h00, 'h0000, 'h00, 0, 1, 0);
    vt[7]  = mk(1, 'h02, 'h00F0, 'h22, 0, 'h01,  1, 1, 'h01, 'h000F, 'h11, 1, 0, 0);
    vt[8]  = mk(1, 'h03, 'h0F00, 'h33, 0, 'h02,  1, 1, 'h01, 'h000F, 'h11, 1, 0, 0);
    vt[9]  = mk(1, 'h04, 'hF000, 'h44, 0, 'h04,  1, 1, 'h01, 'h000F, 'h11, 0, 0, 0);
    vt[10] = mk(0, 'h00, 'h0000, 'h00, 0, 'h03,  0, 1, 'h01, 'h000F, 'h11, 1, 0, 1);
    vt[11] = mk(1, 'h09, 'hFFFF, 'h99, 0, 'h09,  0, 1, 'h01, 'h000F, 'h11, 0, 0, 1);
    vt[12] = mk(0, 'h00, 'h0000, 'h00, 1, 'h04,  0, 1, 'h01, 'h000F, 'h11, 1, 0, 1);
    vt[13] = mk(0, 'h00, 'h0000, 'h00, 1, 'h01,  1, 1, 'h02, 'h00F0, 'h22, 0, 0, 0);
    vt[14] = mk(0, 'h00, 'h0000, 'h00, 1, 'h04,  1, 1, 'h03, 'h0F00, 'h33, 1, 0, 0);
    vt[15] = mk(0, 'h00, 'h0000, 'h00, 1, 'h04,  1, 1, 'h04, 'hF000, 'h44, 1, 0, 0);
    vt[16] = mk(0, 'h00, 'h0000, 'h00, 0, 'h04,  1, 0, 'h00, 'h0000, 'h00, 0, 1, 0);
    vt[17] = mk(1, 'h31, 'hFFFF, 'h31, 0, 'h00,  1, 0, 'h00, 'h0000, 'h00, 0, 1, 0);
    vt[18] = mk(1, 'h32, 'hFFFF, 'h32, 0, 'h00,  1, 1, 'h31, 'hFFFF, 'h31, 0, 0, 0);
    vt[19] = mk(1, 'h33, 'hFFFF, 'h33, 0, 'h00,  1, 1, 'h31, 'hFFFF, 'h31, 0, 0, 0);
    vt[20] = mk(1, 'h34, 'hFFFF, 'h34, 0, 'h00,  1, 1, 'h31, 'hFFFF, 'h31, 0, 0, 0);
    vt[21] = mk(1, 'h35, 'hFFFF, 'h35, 1, 'h35,  0, 1, 'h31, 'hFFFF, 'h31, 0, 0, 1);
    vt[22] = mk(0, 'h00, 'h0000, 'h00, 0, 'h35,  1, 1, 'h32, 'hFFFF, 'h32, 0, 0, 0);
    vt[23] = mk(0, 'h00, 'h0000, 'h00, 1, 'h32,  1, 1, 'h32, 'hFFFF, 'h32, 1, 0, 0);
    vt[24] = mk(0, 'h00, 'h0000, 'h00, 1, 'h32,  1, 1, 'h33, 'hFFFF, 'h33, 0, 0, 0);
    vt[25] = mk(0, 'h00, 'h0000, 'h00, 1, 'h34,  1, 1, 'h34, 'hFFFF, 'h34, 1, 0, 0);
    vt[26] = mk(0, 'h00, 'h0000, 'h00, 0, 'h34,  1, 0, 'h00, 'h0000, 'h00, 0, 1, 0);

    drive(0, '0, '0, '0, 0, '0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    for (int k = 0; k < 27; k++) begin
      drive(vt[k].v, vt[k].a, vt[k].be, {16{vt[k].db}}, vt[k].rdy, vt[k].lk);
      #1;
      chk($sformatf("v%0d_ready", k), 128'(evict_ready), 128'(vt[k].er));
      chk($sformatf("v%0d_mvalid", k), 128'(mem_req_valid), 128'(vt[k].mv));
      chk($sformatf("v%0d_maddr", k), 128'(mem_req_addr), 128'(vt[k].ma));
      chk($sformatf("v%0d_mbyteen", k), 128'(mem_req_byteen), 128'(vt[k].mb));
      chk($sformatf("v%0d_mdata", k), mem_req_data, {16{vt[k].md}});
      chk($sformatf("v%0d_hit", k), 128'(lookup_hit), 128'(vt[k].hit));
      chk($sformatf("v%0d_empty", k), 128'(empty), 128'(vt[k].emp));
      chk($sformatf("v%0d_full", k), 128'(full), 128'(vt[k].fl));
      tick();
    end

    // Asynchronous reset mid-operation, then a fresh push must be first out.
    drive(1, 'h40, 'hFFFF, {16{8'h40}}, 0, 'h40);
    tick();
    drive(1, 'h41, 'hFFFF, {16{8'h41}}, 0, 'h40);
    tick();
    drive(0, '0, '0, '0, 0, 'h40);
    #1;
    chk_head("prerst", 'h40, 'hFFFF, {16{8'h40}});
    reset = 1'b0;
    #1;
    chk("rst_mvalid", 128'(mem_req_valid), 128'(1'b0));
    chk("rst_empty", 128'(empty), 128'(1'b1));
    chk("rst_full", 128'(full), 128'(1'b0));
    chk("rst_ready", 128'(evict_ready), 128'(1'b1));
    chk("rst_hit", 128'(lookup_hit), 128'(1'b0));
    chk("rst_maddr", 128'(mem_req_addr), 128'(0));
    chk("rst_mbyteen", 128'(mem_req_byteen), 128'(0));
    chk("rst_mdata", mem_req_data, 128'(0));
    tick();
    tick();
    reset = 1'b1;
    drive(1, 'h07, 'h0003, {16{8'h77}}, 0, 'h07);
    #1;
    chk("post_nobypass", 128'(mem_req_valid), 128'(1'b0));
    tick();
    drive(0, '0, '0, '0, 1, 'h07);
    #1;
    chk_head("post_first", 'h07, 'h0003, {16{8'h77}});
    chk("post_hit", 128'(lookup_hit), 128'(1'b1));
    tick();
    drive(0, '0, '0, '0, 0, 'h07);
    #1;
    chk("post_empty", 128'(empty), 128'(1'b1));

    // Same-address evictions: merged with the macro, duplicated without it.
    mdata  = {{8{8'hCC}}, {4{8'hBB}}, {4{8'hCC}}};
    merged = {{8{8'h66}}, {4{8'hBB}}, {4{8'h66}}};
    drive(1, 'h05, 'hFFFF, {16{8'h55}}, 0, '0);
    tick();
    drive(1, 'h06, 'h000F, {16{8'h66}}, 0, '0);
    tick();
    drive(1, 'h06, 'h00F0, mdata, 0, '0);
    #1;
    chk("dup_ready", 128'(evict_ready), 128'(1'b1));
    tick();
    drive(1, 'h05, 'h0100, {16{8'h57}}, 0, '0);
    tick();
    drive(0, '0, '0, '0, 0, '0);
    #1;
`ifdef CS_WB_MERGE_EN
    chk("mrg_full", 128'(full), 128'(1'b0));
`else
    chk("dup_full", 128'(full), 128'(1'b1));
`endif
    drive(0, '0, '0, '0, 1, '0);
    #1;
    chk_head("drain0", 'h05, 'hFFFF, {16{8'h55}});
    tick();
`ifdef CS_WB_MERGE_EN
    chk_head("mrg1", 'h06, 'h00FF, merged);
    tick();
`else
    chk_head("dup1", 'h06, 'h000F, {16{8'h66}});
    tick();
    chk_head("dup2", 'h06, 'h00F0, mdata);
    tick();
`endif
    chk_head("drain_last", 'h05, 'h0100, {16{8'h57}});
    tick();
    drive(0, '0, '0, '0, 0, '0);
    #1;
    chk("drain_empty", 128'(empty), 128'(1'b1));
    chk("drain_mvalid", 128'(mem_req_valid), 128'(1'b0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
